fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_ctrl.sv | 102 ++++++++++
 tb/tb_fetch_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the two-byte instruction fetch controller.
package fetch_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 8;

    localparam logic [INSTR_W-1:0] OP_HALT = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_F1,
        S_W1,
        S_F2,
        S_W2,
        S_VALID,
        S_HALTED
    } state_t;

    // Opcodes with the top bit set carry a second (operand) byte.
    function automatic logic is_two_byte(input logic [INSTR_W-1:0] op);
        return op[INSTR_W-1];
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: reads one- or two-byte instructions from a
// synchronous memory, presents them on a valid/ready interface, supports
// redirect on handshake and stops on the HALT opcode.
module fetch_ctrl
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [ADDR_W-1:0]  iAddr,
    output logic               FETCH,
    input  logic [INSTR_W-1:0] instr,
    output logic [INSTR_W-1:0] ir,
    output logic [INSTR_W-1:0] operand,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               jmp_en,
    input  logic [ADDR_W-1:0]  jmp_addr,
    output logic               halted
);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   pc, pc_nxt;
    logic [INSTR_W-1:0]  ir_nxt, opnd_nxt;
    logic                fetch_nxt;

    // The memory interface is driven from the next state so that FETCH and
    // iAddr are registered yet line up exactly with the F1/F2 cycles.
    assign fetch_nxt = (state_nxt == S_F1) || (state_nxt == S_F2);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state, program counter and instruction latch decisions.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        opnd_nxt  = operand;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_F1;
                    pc_nxt    = '0;
                end
            end
            S_F1: state_nxt = S_W1;
            S_W1: begin
                ir_nxt = instr;
                pc_nxt = pc + ADDR_W'(1);
                if (instr == OP_HALT)      state_nxt = S_HALTED;
                else if (is_two_byte(instr)) state_nxt = S_F2;
                else                        state_nxt = S_VALID;
            end
            S_F2: state_nxt = S_W2;
            S_W2: begin
                opnd_nxt  = instr;
                pc_nxt    = pc + ADDR_W'(1);
                state_nxt = S_VALID;
            end
            S_VALID: begin
                // Redirect is only honoured on the accepting cycle.
                if (ir_ready) begin
                    if (jmp_en) pc_nxt = jmp_addr;
                    state_nxt = S_F1;
                end
            end
            S_HALTED: begin
                if (start) begin
                    state_nxt = S_F1;
                    pc_nxt    = '0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; iAddr only moves when a fetch is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= '0;
            iAddr    <= '0;
            FETCH    <= 1'b0;
            ir       <= '0;
            operand  <= '0;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            pc       <= pc_nxt;
            ir       <= ir_nxt;
            operand  <= opnd_nxt;
            FETCH    <= fetch_nxt;
            if (fetch_nxt) iAddr <= pc_nxt;
            ir_valid <= (state_nxt == S_VALID);
            halted   <= (state_nxt == S_HALTED);
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a transaction-level model predicts each
// presented instruction (content, cycle, last fetch address) and a monitor
// compares what the DUT shows.
module tb_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] iAddr;
    logic       FETCH;
    logic [7:0] instr = 8'h00;
    logic [7:0] ir;
    logic [7:0] operand;
    logic       ir_valid;
    logic       ir_ready = 1'b0;
    logic       jmp_en = 1'b0;
    logic [7:0] jmp_addr = 8'h00;
    logic       halted;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] mem [256];

    fetch_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .iAddr(iAddr), .FETCH(FETCH),
        .instr(instr), .ir(ir), .operand(operand), .ir_valid(ir_valid),
        .ir_ready(ir_ready), .jmp_en(jmp_en), .jmp_addr(jmp_addr), .halted(halted)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data appears the cycle after FETCH.
    always @(posedge clk) if (FETCH) instr <= mem[iAddr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         due;
        bit         halt;
        logic [7:0] ir;
        logic [7:0] opnd;
        logic [7:0] addr;
    } exp_t;

    exp_t       q[$];
    int         mmode = 0;   // 0 idle, 1 instruction in flight/presented, 2 halting/halted
    int         mdue  = 0;
    logic [7:0] mpc   = 8'h00;
    logic [7:0] mopnd = 8'h00;
    int         n;

    // Decode the instruction at address a, fetch begins the cycle after n.
    task automatic issue(input logic [7:0] a, input int now);
        exp_t       e;
        logic [7:0] op;
        op     = mem[a];
        e.ir   = op;
        e.halt = (op == 8'hFF);
        if (e.halt) begin
            e.due = now + 3; e.opnd = mopnd; e.addr = a;
            mpc = a + 8'd1; mmode = 2;
        end else if (op[7]) begin
            mopnd = mem[8'(a + 8'd1)];
            e.due = now + 5; e.opnd = mopnd; e.addr = a + 8'd1;
            mpc = a + 8'd2; mmode = 1;
        end else begin
            e.due = now + 3; e.opnd = mopnd; e.addr = a;
            mpc = a + 8'd1; mmode = 1;
        end
        mdue = e.due;
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        n = cyc;
        if (rst) begin
            foreach (q[i]) if (q[i].due <= n) begin
                total++; bad++;
                $display("FAIL missed: instruction %0h due cycle %0d never presented", q[i].ir, q[i].due);
            end
            q.delete();
            mmode = 0; mopnd = 8'h00; mpc = 8'h00;
        end else begin
            case (mmode)
                0: if (start) issue(8'h00, n);
                1: if (n >= mdue && ir_ready) issue(jmp_en ? jmp_addr : mpc, n);
                2: if (n >= mdue && start) issue(8'h00, n);
                default: mmode = 0;
            endcase
        end
        cyc++;
    end

    // ---------------- monitor ----------------
    bit   pv = 1'b0, ph = 1'b0;
    exp_t m;
    always @(negedge clk) begin
        if ((ir_valid && !pv) || (halted && !ph)) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected: ir_valid=%0b halted=%0b ir=%0h with nothing expected (cycle %0d)",
                         ir_valid, halted, ir, cyc);
            end else begin
                m = q.pop_front();
                chk("halt_kind", {31'd0, halted}, {31'd0, m.halt});
                chk("valid_kind", {31'd0, ir_valid}, {31'd0, !m.halt});
                chk("cycle", cyc, m.due);
                chk("ir", {24'd0, ir}, {24'd0, m.ir});
                if (!m.halt) chk("operand", {24'd0, operand}, {24'd0, m.opnd});
                chk("iAddr_last", {24'd0, iAddr}, {24'd0, m.addr});
            end
        end
        chk("fetch_quiet", {31'd0, FETCH & (ir_valid | halted)}, 32'd0);
        pv = ir_valid;
        ph = halted;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic fill_mem(input bit allow_halt);
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            if (!allow_halt && mem[i] == 8'hFF) mem[i] = 8'h7F;
            if (allow_halt && ($urandom % 24) == 0) mem[i] = 8'hFF;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        @(negedge clk);
        chk({tag, "_iAddr"},    {24'd0, iAddr},    32'd0);
        chk({tag, "_FETCH"},    {31'd0, FETCH},    32'd0);
        chk({tag, "_ir"},       {24'd0, ir},       32'd0);
        chk({tag, "_operand"},  {24'd0, operand},  32'd0);
        chk({tag, "_ir_valid"}, {31'd0, ir_valid}, 32'd0);
        chk({tag, "_halted"},   {31'd0, halted},   32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; ir_ready = 1'b0; jmp_en = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ir_valid) return;
        end
        total++; bad++;
        $display("FAIL %s_timeout: ir_valid not seen within 50 cycles", tag);
    endtask

    initial begin
        // Reset state
        do_reset();
        check_reset_vals("reset");

        // One-byte instructions back to back
        fill_mem(0);
        mem[0] = 8'h11; mem[1] = 8'h22;
        do_reset();
        ir_ready = 1'b1;
        pulse_start();
        repeat (10) tick();

        // Two-byte instruction
        fill_mem(0);
        mem[0] = 8'h85; mem[1] = 8'h3C; mem[2] = 8'h05;
        do_reset();
        ir_ready = 1'b1;
        pulse_start();
        repeat (10) tick();

        // Consumer stall for four cycles
        fill_mem(0);
        mem[0] = 8'h11;
        do_reset();
        pulse_start();
        wait_valid("stall");
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            chk("stall_valid", {31'd0, ir_valid}, 32'd1);
            chk("stall_fetch", {31'd0, FETCH},    32'd0);
            chk("stall_ir",    {24'd0, ir},       32'h11);
        end
        ir_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("release_fetch", {31'd0, FETCH}, 32'd1);
        repeat (6) tick();

        // Redirect on handshake; jmp_en held high through W1 too
        fill_mem(0);
        mem[0] = 8'h11; mem[8'h40] = 8'h22;
        do_reset();
        ir_ready = 1'b1; jmp_en = 1'b1; jmp_addr = 8'h40;
        pulse_start();
        repeat (12) tick();
        jmp_en = 1'b0;

        // HALT then restart
        fill_mem(0);
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'hFF;
        do_reset();
        ir_ready = 1'b1;
        pulse_start();
        repeat (12) tick();
        @(negedge clk);
        chk("halt_hold",  {31'd0, halted}, 32'd1);
        chk("halt_fetch", {31'd0, FETCH},  32'd0);
        pulse_start();
        @(negedge clk);
        chk("restart_iAddr", {24'd0, iAddr}, 32'd0);
        chk("restart_halted", {31'd0, halted}, 32'd0);
        repeat (8) tick();

        // Operand wraps past 8'hFF, then reset lands in W2
        fill_mem(0);
        mem[0] = 8'h07; mem[8'hFF] = 8'h90; mem[1] = 8'h90; mem[2] = 8'h33;
        do_reset();
        ir_ready = 1'b1; jmp_en = 1'b1; jmp_addr = 8'hFF;
        pulse_start();
        wait_valid("wrap0");
        tick();
        jmp_en = 1'b0;
        wait_valid("wrap1");
        chk("wrap_operand", {24'd0, operand}, 32'h07);
        chk("wrap_iAddr",   {24'd0, iAddr},   32'h00);
        repeat (4) tick();
        chk("pre_reset_F2", {24'd0, iAddr}, 32'h02);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals("midreset");

        // Randomized traffic with halts, stalls, jumps and occasional reset
        fill_mem(1);
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            start    = ($urandom % 8) == 0;
            ir_ready = ($urandom % 3) != 0;
            jmp_en   = ($urandom % 4) == 0;
            jmp_addr = 8'($urandom);
            rst      = ($urandom % 200) == 0;
            tick();
        end
        start = 1'b0; ir_ready = 1'b1; jmp_en = 1'b0; rst = 1'b0;
        repeat (10) tick();
        do_reset();
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
